// File: rtl/uart_rx_if.sv
// Signal bundle between the RX pin / byte consumer and the uart_rx receiver.
// The receiver uses the slave view; the pin driver and consumer use the master view.
interface uart_rx_if;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx, rx_ack,
    input  rx_data, rx_valid, overrun, frame_err, busy
  );

  modport slave (
    input  rx, rx_ack,
    output rx_data, rx_valid, overrun, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling from the master clock.
// Samples each bit at mid-bit, phase-locked to the detected start edge.
module uart_rx #(
  parameter int unsigned master_clock = 24_000_000,
  parameter int unsigned baud_rate    = 115200
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);

  localparam int unsigned OSR_DIV = master_clock / (baud_rate * 16);
  localparam int unsigned TICK_W  = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OSR_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]          samp_cnt_q, samp_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                overrun_q, overrun_d;
  logic                frame_err_q, frame_err_d;
  logic                rxs, tick, ack_hit;

  assign rxs     = sync_q[1];
  assign tick    = (tick_cnt_q == TICK_LAST);
  assign ack_hit = bus.rx_ack && rx_valid_q;

  // NOTE: the synchroniser resets to the idle-high line level so that leaving
  // reset cannot look like a falling start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.rx};
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: every next-state value gets a default before the case statement,
  // which keeps this block purely combinational (no inferred latches).
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    samp_cnt_d  = samp_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;

    if (ack_hit) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        samp_cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (tick) begin
          if (samp_cnt_q == 4'd7) begin
            samp_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rxs ? IDLE : DATA;
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == 4'd15) begin
            shift_d   = {rxs, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == 4'd15) begin
            if (rxs) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              // An ack landing on the same edge wins: the old byte was consumed.
              if (rx_valid_q && !bus.rx_ack) overrun_d = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx at the default 208-clock bit period.
// Expected flags come from a frame-level model of the receive/ack protocol.
module tb_uart_rx;

  localparam int BIT_CLKS  = 208;
  localparam int FRAME_CLK = 10 * BIT_CLKS;
  // Stop bit is judged on the edge 2 sync + 1 detect + 8 + 9*16 ticks of 13 clocks after the start drive.
  localparam int STOP_EDGE = 3 + 13 * (8 + 9 * 16);

  logic clk = 1'b0;
  logic rst;

  uart_rx_if bus ();

  uart_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int fe_cycles    = 0;
  int fe_base;

  logic [7:0] model_data;
  logic       model_valid;
  logic       model_overrun;

  logic busy_c3, busy_pre_stop, busy_post_stop;

  always @(negedge clk) if (bus.frame_err === 1'b1) fe_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; cycle c of the frame is driven at negedge c.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int ack_at, input int abort_at);
    int idx;
    for (int c = 0; c < FRAME_CLK; c++) begin
      if (c == abort_at) return;
      idx = c / BIT_CLKS;
      if (idx == 0)      bus.rx = 1'b0;
      else if (idx <= 8) bus.rx = b[idx-1];
      else               bus.rx = stop_bit;
      bus.rx_ack = (c == ack_at);
      if (c == 3)             busy_c3        = bus.busy;
      if (c == STOP_EDGE - 1) busy_pre_stop  = bus.busy;
      if (c == STOP_EDGE)     busy_post_stop = bus.busy;
      @(negedge clk);
    end
    bus.rx_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
  endtask

  function automatic void model_frame(input logic [7:0] b, input logic good, input logic ack_same);
    if (good) begin
      if (ack_same && model_valid) model_overrun = 1'b0;
      else if (model_valid)        model_overrun = 1'b1;
      model_valid = 1'b1;
      model_data  = b;
    end
  endfunction

  function automatic void model_ack();
    model_valid   = 1'b0;
    model_overrun = 1'b0;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".data"},    bus.rx_data,  model_data);
    check({tag, ".valid"},   bus.rx_valid, model_valid);
    check({tag, ".overrun"}, bus.overrun,  model_overrun);
  endtask

  task automatic check_good_timing(input string tag);
    check({tag, ".busy_rise"},     busy_c3,        1'b1);
    check({tag, ".busy_pre_stop"}, busy_pre_stop,  1'b1);
    check({tag, ".busy_fall"},     busy_post_stop, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic       coincide;

    rst = 1'b1;
    bus.rx = 1'b1;
    bus.rx_ack = 1'b0;
    model_data = 8'h00; model_valid = 1'b0; model_overrun = 1'b0;
    repeat (4) @(negedge clk);
    check("reset.data",      bus.rx_data,   8'h00);
    check("reset.valid",     bus.rx_valid,  1'b0);
    check("reset.overrun",   bus.overrun,   1'b0);
    check("reset.frame_err", bus.frame_err, 1'b0);
    check("reset.busy",      bus.busy,      1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("release.busy", bus.busy, 1'b0);

    // Normal byte, then ack; a second ack with nothing pending changes nothing.
    fe_base = fe_cycles;
    send_frame(8'hA5, 1'b1, -1, -1);
    model_frame(8'hA5, 1'b1, 1'b0);
    check_model("a5");
    check_good_timing("a5");
    check("a5.frame_err", fe_cycles - fe_base, 0);
    ack_pulse(); model_ack();
    check_model("a5_ack");
    ack_pulse();
    check_model("idle_ack");

    // Glitch shorter than half a bit.
    fe_base = fe_cycles;
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    check("glitch.busy_seen", bus.busy, 1'b1);
    repeat (10) @(negedge clk);
    bus.rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch.busy", bus.busy, 1'b0);
    check("glitch.frame_err", fe_cycles - fe_base, 0);
    check_model("glitch");

    // Framing error followed by a long break.
    fe_base = fe_cycles;
    send_frame(8'h3C, 1'b0, -1, -1);
    repeat (1000) @(negedge clk);
    check("ferr.pulses", fe_cycles - fe_base, 1);
    check("ferr.busy_held", bus.busy, 1'b1);
    check_model("ferr");
    bus.rx = 1'b1;
    repeat (6) @(negedge clk);
    check("ferr.busy_release", bus.busy, 1'b0);

    // Overrun from two back-to-back frames.
    send_frame(8'h11, 1'b1, -1, -1); model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, -1, -1); model_frame(8'h22, 1'b1, 1'b0);
    check_good_timing("b2b");
    check_model("overrun");
    ack_pulse(); model_ack();
    check_model("overrun_ack");

    // Ack on the exact edge the second stop bit is accepted.
    send_frame(8'h5A, 1'b1, -1, -1);         model_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, STOP_EDGE - 1, -1); model_frame(8'hC3, 1'b1, 1'b1);
    check_model("ack_coincide");

    // Randomized frames with random acks between and on the stop edge.
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse(); model_ack();
      end
      coincide = model_valid && ($urandom_range(0, 2) == 0);
      send_frame(b, 1'b1, coincide ? STOP_EDGE - 1 : -1, -1);
      model_frame(b, 1'b1, coincide);
      check_model($sformatf("rand%0d", i));
      check_good_timing($sformatf("rand%0d", i));
    end

    // Reset in the middle of data bit 3 with a byte still pending.
    send_frame(8'h77, 1'b1, -1, -1); model_frame(8'h77, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, -1, 4 * BIT_CLKS + 100);
    check("pre_rst.busy", bus.busy, 1'b1);
    rst = 1'b1;
    bus.rx = 1'b1;
    #1;
    check("mid_rst.data",    bus.rx_data,  8'h00);
    check("mid_rst.valid",   bus.rx_valid, 1'b0);
    check("mid_rst.overrun", bus.overrun,  1'b0);
    check("mid_rst.busy",    bus.busy,     1'b0);
    model_data = 8'h00; model_valid = 1'b0; model_overrun = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    fe_base = fe_cycles;
    repeat (2500) @(negedge clk);
    check_model("post_rst");
    check("post_rst.busy", bus.busy, 1'b0);
    check("post_rst.frame_err", fe_cycles - fe_base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
